// File: rtl/serial_subtractor32.sv
// -----------------------------------------------------------------------------
// serial_subtractor32
//
// Multi-cycle bit-serial two's-complement subtractor. Computes
//   diff = a - b - bin (mod 2^WIDTH) and the unsigned borrow-out bout
// over N = WIDTH/BITS_PER_CYCLE RUN cycles. Each cycle retires one
// LSB-first slice of BITS_PER_CYCLE bits through a chained full-subtractor.
//
// Parameters:
//   WIDTH          operand/result width (default 32)
//   BITS_PER_CYCLE bits retired per RUN cycle; must divide WIDTH (1,2,4,8)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only in IDLE
//   a, b   in   minuend / subtrahend, sampled with an accepted start
//   bin    in   borrow-in, sampled with an accepted start
//   busy   out  high while in RUN or DONE
//   done   out  one-cycle pulse; diff/bout valid from this cycle on
//   diff   out  a - b - bin
//   bout   out  1 when a < b + bin (unsigned)
//   ovf    out  signed overflow flag (only when SERIAL_SUB_OVF_EN is defined)
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the registered ovf output.
// -----------------------------------------------------------------------------
module serial_subtractor32 #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             br_q,     br_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
  logic             done_q,   done_d;
  logic             busy_q,   busy_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q,  a_msb_d;
  logic             b_msb_q,  b_msb_d;
  logic             ovf_q,    ovf_d;
`endif

  logic [BITS_PER_CYCLE-1:0] slice_diff;
  logic                      slice_bout;
  logic                      br_chain;
  logic [WIDTH-1:0]          res_shift;

  // Chained full-subtractor over the current low slice of the operand shifters.
  always_comb begin
    br_chain   = br_q;
    slice_diff = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      slice_diff[i] = a_sh_q[i] ^ b_sh_q[i] ^ br_chain;
      br_chain      = (~a_sh_q[i] & b_sh_q[i]) | (~(a_sh_q[i] ^ b_sh_q[i]) & br_chain);
    end
    slice_bout = br_chain;
  end

  // New slices enter at the MSB end so after N slices bit 0 sits at bit 0.
  assign res_shift = {slice_diff, res_q[WIDTH-1:BITS_PER_CYCLE]};

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = CNT_ZERO;
          state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> BITS_PER_CYCLE;
        b_sh_d = b_sh_q >> BITS_PER_CYCLE;
        res_d  = res_shift;
        br_d   = slice_bout;
        if (cnt_q == CNT_LAST) begin
          // Final slice: publish the result and wrap the counter.
          cnt_d   = CNT_ZERO;
          diff_d  = res_shift;
          bout_d  = slice_bout;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (res_shift[WIDTH-1] ^ a_msb_q);
`endif
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy is registered, so it is derived from the state being entered.
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
